// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: MIPS funct codes and FSM states.
package alu_pkg;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between decode/register-read and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] hi;
  logic             ovf;
  logic             zero;
  logic             illegal;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, func, a, b, out_ready,
    input  in_ready, out_valid, res, hi, ovf, zero, illegal
  );

  // The ALU itself.
  modport slave (
    input  in_valid, func, a, b, out_ready,
    output in_ready, out_valid, res, hi, ovf, zero, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// product is combinational: while done is high it already includes the final
// partial product, so the caller captures it on the same edge.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = (cnt == CNT_W'(1));

  // Load operands on start, then fold in one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered MIPS R-type ALU with valid/ready handshake. Single-cycle ops
// return the cycle after acceptance; multu is handed to the iterative
// multiplier and the block stalls until its result has been consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_t state, state_nxt;

  logic               in_rdy;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               load_sc;
  logic               load_mul;
  logic               clr_ov;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] amt;
  logic               amt_big;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               sc_ill;

  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  logic               ovf_q;
  logic               zero_q;
  logic               ill_q;
  logic               ov_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath; unsupported codes flag illegal with a zero result.
  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    amt     = bus.b[SHAMT_W-1:0];
    amt_big = ({1'b0, amt} >= (SHAMT_W+1)'(WIDTH));
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_ill  = 1'b0;
    case (bus.func)
      FN_ADD: begin
        sc_res = sum;
        sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      FN_ADDU: sc_res = sum;
      FN_SUB: begin
        sc_res = diff;
        sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      FN_SUBU: sc_res = diff;
      FN_AND:  sc_res = bus.a & bus.b;
      FN_OR:   sc_res = bus.a | bus.b;
      FN_XOR:  sc_res = bus.a ^ bus.b;
      FN_NOR:  sc_res = ~(bus.a | bus.b);
      FN_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      FN_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      FN_SLLV: sc_res = amt_big ? '0 : (bus.a << amt);
      FN_SRLV: sc_res = amt_big ? '0 : (bus.a >> amt);
      FN_SRAV: sc_res = amt_big ? {WIDTH{bus.a[WIDTH-1]}} : WIDTH'($signed(bus.a) >>> amt);
      FN_MULTU: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, input readiness and output-register load controls.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    mul_start = 1'b0;
    load_sc   = 1'b0;
    load_mul  = 1'b0;
    clr_ov    = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = !ov_q || bus.out_ready;
        if (bus.in_valid && in_rdy) begin
          if (bus.func == FN_MULTU) begin
            mul_start = 1'b1;
            clr_ov    = 1'b1;
            state_nxt = MUL;
          end else begin
            load_sc = 1'b1;
          end
        end else if (ov_q && bus.out_ready) begin
          clr_ov = 1'b1;
        end
      end
      MUL: begin
        if (mul_done) begin
          load_mul  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          clr_ov    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: hold while stalled, reload on a new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      hi_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else if (load_sc) begin
      res_q  <= sc_res;
      hi_q   <= '0;
      ovf_q  <= sc_ovf;
      zero_q <= (sc_res == '0);
      ill_q  <= sc_ill;
      ov_q   <= 1'b1;
    end else if (load_mul) begin
      res_q  <= mul_prod[WIDTH-1:0];
      hi_q   <= mul_prod[2*WIDTH-1:WIDTH];
      ovf_q  <= 1'b0;
      zero_q <= (mul_prod == '0);
      ill_q  <= 1'b0;
      ov_q   <= 1'b1;
    end else if (clr_ov) begin
      ov_q   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.res       = res_q;
  assign bus.hi        = hi_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: table of vectors through a scoreboard plus
// hand-written sequences for multiply latency, back-pressure and reset.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       ovf;
    logic       zero;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [5:0] f;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   ndone = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bus();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t v(logic [5:0] f, logic [7:0] a, logic [7:0] b,
                             logic [7:0] r, logic [7:0] h, logic o, logic z, logic il);
    vec_t t;
    t.f = f; t.a = a; t.b = b;
    t.e.res = r; t.e.hi = h; t.e.ovf = o; t.e.zero = z; t.e.ill = il;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one op, push its expected result when the handshake completes.
  task automatic send(input logic [5:0] f, input logic [7:0] av, input logic [7:0] bv,
                      input exp_t e, output int waits);
    bit acc = 0;
    waits = 0;
    bus.in_valid = 1'b1; bus.func = f; bus.a = av; bus.b = bv;
    while (!acc && waits <= 40) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1;
      else waits++;
    end
    if (acc) begin
      q.push_back(e);
      @(posedge clk); #1;
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  // Scoreboard: compare each result at the negedge before it transfers.
  always @(negedge clk) begin
    exp_t e, act;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      act = {bus.res, bus.hi, bus.ovf, bus.zero, bus.illegal};
      if (q.size() == 0) begin
        chk("unexpected_output", {13'd0, act}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("result{res,hi,ovf,zero,ill}", {13'd0, act}, {13'd0, e});
      end
      ndone++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   w;
    int   lat;
    int   d0;
    bit   prev_mul;
    bit   seen;

    tbl.push_back(v(6'b100000, 8'h7F, 8'h01, 8'h80, 8'h00, 1, 0, 0)); // add ovf
    tbl.push_back(v(6'b100001, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 0)); // addu
    tbl.push_back(v(6'b100011, 8'h00, 8'h01, 8'hFF, 8'h00, 0, 0, 0)); // subu
    tbl.push_back(v(6'b100010, 8'h80, 8'h01, 8'h7F, 8'h00, 1, 0, 0)); // sub ovf
    tbl.push_back(v(6'b101010, 8'hFF, 8'h01, 8'h01, 8'h00, 0, 0, 0)); // slt
    tbl.push_back(v(6'b101011, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 1, 0)); // sltu
    tbl.push_back(v(6'b000111, 8'h80, 8'h03, 8'hF0, 8'h00, 0, 0, 0)); // srav
    tbl.push_back(v(6'b000100, 8'h80, 8'h09, 8'h00, 8'h00, 0, 1, 0)); // sllv
    tbl.push_back(v(6'b000100, 8'h01, 8'h07, 8'h80, 8'h00, 0, 0, 0)); // sllv max
    tbl.push_back(v(6'b000110, 8'h80, 8'h03, 8'h10, 8'h00, 0, 0, 0)); // srlv
    tbl.push_back(v(6'b100100, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0)); // and
    tbl.push_back(v(6'b100101, 8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0)); // or
    tbl.push_back(v(6'b100110, 8'hFF, 8'h0F, 8'hF0, 8'h00, 0, 0, 0)); // xor
    tbl.push_back(v(6'b100111, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 0)); // nor
    tbl.push_back(v(6'b100000, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 1, 0)); // add carry only
    tbl.push_back(v(6'b100010, 8'h7F, 8'hFF, 8'h80, 8'h00, 1, 0, 0)); // sub ovf
    tbl.push_back(v(6'b111111, 8'h12, 8'h34, 8'h00, 8'h00, 0, 1, 1)); // illegal
    tbl.push_back(v(6'b011001, 8'h0D, 8'h0B, 8'h8F, 8'h00, 0, 0, 0)); // multu
    tbl.push_back(v(6'b011001, 8'h00, 8'h55, 8'h00, 8'h00, 0, 1, 0)); // multu zero
    tbl.push_back(v(6'b100001, 8'h10, 8'h20, 8'h30, 8'h00, 0, 0, 0)); // addu after mul

    bus.in_valid = 1'b0; bus.func = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_flags{ovf,zero,ill}", {bus.ovf, bus.zero, bus.illegal}, 0);
    @(posedge clk); #1;

    // Single-cycle latency.
    send(6'b100000, 8'h7F, 8'h01, exp_t'{8'h80, 8'h00, 1'b1, 1'b0, 1'b0}, w);
    chk("add_latency_out_valid", bus.out_valid, 1);
    wait_drain();

    // Table, back-to-back with out_ready high: no stalls except behind multu.
    prev_mul = 0;
    foreach (tbl[i]) begin
      send(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].e, w);
      if (!prev_mul) chk($sformatf("no_stall[%0d]", i), w, 0);
      prev_mul = (tbl[i].f == 6'b011001);
    end
    wait_drain();

    // multu latency and in_ready low throughout, result held under back-pressure.
    bus.out_ready = 1'b0;
    send(6'b011001, 8'hFF, 8'hFF, exp_t'{8'h01, 8'hFE, 1'b0, 1'b0, 1'b0}, w);
    lat = 0;
    chk("mul_out_valid_k0", bus.out_valid, 0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid && lat == 0) lat = k;
      chk($sformatf("mul_in_ready_k%0d", k), bus.in_ready, 0);
    end
    chk("mul_latency", lat, 8);
    bus.out_ready = 1'b1;
    wait_drain();
    @(posedge clk); #1;
    chk("mul_in_ready_after", bus.in_ready, 1);

    // Back-pressure on back-to-back single-cycle ops.
    bus.out_ready = 1'b0;
    d0 = ndone;
    send(6'b100100, 8'hF0, 8'h3C, exp_t'{8'h30, 8'h00, 1'b0, 1'b0, 1'b0}, w);
    fork
      send(6'b100100, 8'h0F, 8'hFF, exp_t'{8'h0F, 8'h00, 1'b0, 1'b0, 1'b0}, w);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("bp_in_ready%0d", k), bus.in_ready, 0);
          chk($sformatf("bp_res_stable%0d", k), bus.res, 8'h30);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk); #1;
    chk("bp_outputs", ndone - d0, 2);

    // Reset four cycles into a multiply.
    send(6'b011001, 8'h12, 8'h34, exp_t'{8'h a8, 8'h03, 1'b0, 1'b0, 1'b0}, w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmul_out_valid", bus.out_valid, 0);
    chk("rstmul_in_ready", bus.in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("rstmul_no_pulse", seen, 0);
    chk("rstmul_in_ready_after", bus.in_ready, 1);
    send(6'b100000, 8'h02, 8'h03, exp_t'{8'h05, 8'h00, 1'b0, 1'b0, 1'b0}, w);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
